// File: rtl/calc_pkg.sv
// calc_pkg: command codes, ALU opcodes, sequencer states and the command-to-ALU opcode map.
package calc_pkg;
  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_LT   = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_LOAD = 4'd10;
  localparam logic [3:0] OP_CLR  = 4'd11;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_LT  = 4'b0111;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  function automatic logic [3:0] alu_op_of(input logic [3:0] op);
    case (op)
      OP_OR:   return ALU_OR;
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_LT:   return ALU_LT;
      OP_SRL:  return ALU_SRL;
      OP_SLL:  return ALU_SLL;
      OP_SRA:  return ALU_SRA;
      OP_XOR:  return ALU_XOR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/alu.sv
// alu: 32-bit combinational ALU; op1 is shifted by op2[4:0], LT is a signed compare.
module alu
  import calc_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  op_i,
  output logic [31:0] y_o,
  output logic        zero_o
);
  always_comb begin
    case (op_i)
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_LT:  y_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ALU_SRL: y_o = a_i >> b_i[4:0];
      ALU_SLL: y_o = a_i << b_i[4:0];
      ALU_SRA: y_o = $signed(a_i) >>> b_i[4:0];
      ALU_XOR: y_o = a_i ^ b_i;
      default: y_o = '0;
    endcase
  end
  assign zero_o = (y_o == '0);
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: accumulator calculator around one shared ALU; MUL is a shift-add loop
// reusing the ALU ADD path, one multiplier bit per cycle.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter bit MUL_EARLY_EXIT = 1'b1,
  parameter int CNT_W          = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_operand,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] acc_out,
  output logic        res_zero,
  output logic        res_ovf,
  output logic        res_err,
  output logic        busy
);
  logic [1:0]       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      opnd_q, opnd_d, acc_q, acc_d;
  logic [31:0]      prod_q, prod_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, err_q, err_d;
  logic [3:0]       alu_op;
  logic [31:0]      alu_a, alu_b, alu_y, prod_nx, mplier_nx, new_acc;
  logic             alu_zero, add_ovf, sub_ovf, mul_end, in_exec, in_mul;
  assign in_exec = (state_q == S_EXEC);
  assign in_mul  = (state_q == S_MUL);
  // ALU idles at AND 0,0 outside EXEC/MUL so its inputs do not toggle.
  assign alu_op = in_exec ? alu_op_of(op_q) : in_mul ? ALU_ADD : ALU_AND;
  assign alu_a  = in_exec ? acc_q : in_mul ? prod_q : '0;
  assign alu_b  = in_exec ? opnd_q : in_mul ? mcand_q : '0;
  alu u_alu (
    .a_i    (alu_a),
    .b_i    (alu_b),
    .op_i   (alu_op),
    .y_o    (alu_y),
    .zero_o (alu_zero)
  );
  assign prod_nx   = mplier_q[0] ? alu_y : prod_q;
  assign mplier_nx = mplier_q >> 1;
  assign mul_end   = (cnt_q == CNT_W'(31)) || (MUL_EARLY_EXIT && mplier_nx == '0);
  assign add_ovf   = (acc_q[31] == opnd_q[31]) && (alu_y[31] != acc_q[31]);
  assign sub_ovf   = (acc_q[31] != opnd_q[31]) && (alu_y[31] != acc_q[31]);
  assign new_acc   = cmd_op == OP_LOAD ? cmd_operand : cmd_op == OP_CLR ? '0 : acc_q;
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        op_d   = cmd_op;
        opnd_d = cmd_operand;
        if (cmd_op == OP_MUL) begin
          state_d  = S_MUL;
          prod_d   = '0;
          mcand_d  = acc_q;
          mplier_d = cmd_operand;
          cnt_d    = '0;
        end else if (cmd_op <= OP_XOR) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_DONE;
          acc_d   = new_acc;
          zero_d  = (new_acc == '0);
          ovf_d   = 1'b0;
          err_d   = (cmd_op > OP_CLR);
        end
      end
      S_EXEC: begin
        state_d = S_DONE;
        acc_d   = alu_y;
        zero_d  = alu_zero;
        ovf_d   = op_q == OP_ADD ? add_ovf : op_q == OP_SUB ? sub_ovf : 1'b0;
        err_d   = 1'b0;
      end
      S_MUL: begin
        prod_d   = prod_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_nx;
        cnt_d    = cnt_q + 1'b1;
        if (mul_end) begin
          state_d = S_DONE;
          acc_d   = prod_nx;
          zero_d  = (prod_nx == '0);
          ovf_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: if (res_ready) state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign acc_out   = acc_q;
  assign res_zero  = zero_q;
  assign res_ovf   = ovf_q;
  assign res_err   = err_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: scoreboard bench; a reference model predicts each result at accept time.
module tb_calc_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [31:0] cmd_operand = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] acc_out;
  logic        res_zero, res_ovf, res_err, busy;
  typedef struct packed {
    logic [31:0] acc;
    logic        z, o, e;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] m_acc = '0;
  int          n_vec = 0;
  int          n_err = 0;
  localparam longint MAXI = 64'sd2147483647;
  localparam longint MINI = -64'sd2147483648;
  calc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_operand (cmd_operand),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .acc_out     (acc_out),
    .res_zero    (res_zero),
    .res_ovf     (res_ovf),
    .res_err     (res_err),
    .busy        (busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] b, input logic [31:0] a);
    exp_t   r;
    longint s;
    r = '{acc: a, z: 1'b0, o: 1'b0, e: 1'b0};
    case (op)
      4'd0: r.acc = a & b;
      4'd1: r.acc = a | b;
      4'd2: begin
        s = longint'($signed(a)) + longint'($signed(b));
        r.acc = a + b;
        r.o = (s > MAXI) || (s < MINI);
      end
      4'd3: begin
        s = longint'($signed(a)) - longint'($signed(b));
        r.acc = a - b;
        r.o = (s > MAXI) || (s < MINI);
      end
      4'd4: r.acc = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5: r.acc = a >> b[4:0];
      4'd6: r.acc = a << b[4:0];
      4'd7: r.acc = $signed(a) >>> b[4:0];
      4'd8: r.acc = a ^ b;
      4'd9: r.acc = a * b;
      4'd10: r.acc = b;
      4'd11: r.acc = '0;
      default: r.e = 1'b1;
    endcase
    r.z = (r.acc == '0);
    return r;
  endfunction
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      check("sb_pending", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("acc", acc_out, e.acc);
        check("zero", {31'b0, res_zero}, {31'b0, e.z});
        check("ovf", {31'b0, res_ovf}, {31'b0, e.o});
        check("err", {31'b0, res_err}, {31'b0, e.e});
      end
    end
  end
  task automatic send(input logic [3:0] op, input logic [31:0] v);
    int n = 0;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_operand = v;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", {31'b0, cmd_ready}, 32'd1);
    if (cmd_ready) begin
      @(posedge clk); #1;
      e = model(op, v, m_acc);
      m_acc = e.acc;
      sb.push_back(e);
    end
    cmd_valid = 1'b0;
  endtask
  task automatic wait_res(output int n);
    n = 0;
    while (!res_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("res_wait", {31'b0, res_valid}, 32'd1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc", acc_out, 32'd0);
    check("rst_zero", {31'b0, res_zero}, 32'd1);
    check("rst_ovf", {31'b0, res_ovf}, 32'd0);
    check("rst_err", {31'b0, res_err}, 32'd0);
    check("rst_valid", {31'b0, res_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ready", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(4'd10, 32'd5);
    send(4'd2, 32'd7);
    check("lat_exec", {31'b0, res_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_done", {31'b0, res_valid}, 32'd1);
    check("lat_acc", acc_out, 32'd12);
    send(4'd10, 32'h7FFF_FFFF);
    send(4'd2, 32'd1);
    send(4'd3, 32'h8000_0000);
    send(4'd10, 32'hFFFF_FFF9);
    send(4'd9, 32'd6);
    wait_res(n);
    check("mul_early_cycles", n, 32'd3);
    check("mul_acc", acc_out, 32'hFFFF_FFD6);
    send(4'd10, 32'd3);
    send(4'd9, 32'h8000_0000);
    wait_res(n);
    check("mul_full_cycles", n, 32'd32);
    send(4'd10, 32'hF000_0000);
    send(4'd7, 32'd4);
    send(4'd4, 32'd0);
    send(4'd13, 32'd77);
    send(4'd15, 32'd0);
    send(4'd11, 32'd9);
    for (int i = 0; i < 30; i++) send(4'($urandom_range(0, 15)), $urandom);
    send(4'd10, 32'd5);
    send(4'd2, 32'd1);
    res_ready = 1'b0;
    wait_res(n);
    cmd_valid = 1'b1;
    cmd_op = 4'd10;
    cmd_operand = 32'd99;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall_valid", {31'b0, res_valid}, 32'd1);
      check("stall_ready", {31'b0, cmd_ready}, 32'd0);
      check("stall_acc", acc_out, 32'd6);
      check("stall_flags", {29'b0, res_zero, res_ovf, res_err}, 32'd0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    send(4'd10, 32'd99);
    send(4'd10, 32'd3);
    send(4'd9, 32'h8000_0000);
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_acc", acc_out, 32'd0);
    check("arst_valid", {31'b0, res_valid}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_ready", {31'b0, cmd_ready}, 32'd1);
    sb.delete();
    m_acc = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(4'd2, 32'd3);
    wait_res(n);
    check("post_rst_acc", acc_out, 32'd3);
    n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
